wb_trace_buffer: RTL and testbench

// - Parametrised writeback trace unit for the pipelined core. Snoops the MEM/WB writeback port and

---
 rtl/wb_trace_buffer.sv | 137 +++++++++++++
 tb/tb_wb_trace_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer -- writeback trace unit for the pipelined core.
//
// Snoops the MEM/WB writeback port, timestamps each watched architectural
// register write with a free-running cycle counter, and queues it in a FIFO
// drained by a valid/ready handshake. The head is first-word-fall-through from
// registered storage, so nothing on the writeback side reaches trace_* in the
// same cycle. Captures that find the FIFO full (with no pop in that cycle) are
// discarded and counted in a saturating drop counter.
//
// Build option:
//   TRACE_HALT_EN  defined   -> stall_req is registered and asserted while the
//                               FIFO holds DEPTH-1 or more entries.
//                  undefined -> stall_req is tied low; overflow only drops.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   enable                   capture enable (draining is never blocked)
//   wb_valid/rd/data/pc      MEM/WB writeback snoop
//   trace_valid/ready        head handshake
//   trace_rd/data/pc/ts      head entry (zero while empty)
//   count, full              occupancy
//   drop_cnt                 lost events, saturating
//   stall_req                back-pressure to the pipeline
module wb_trace_buffer #(
    parameter int          XLEN       = 64,
    parameter int          PC_W       = 32,
    parameter int          DEPTH      = 16,
    parameter int          TS_W       = 32,
    parameter logic [31:0] WATCH_MASK = 32'hFFFF_FFFE,
    parameter int          DROP_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [PC_W-1:0]           wb_pc,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [4:0]                trace_rd,
    output logic [XLEN-1:0]           trace_data,
    output logic [PC_W-1:0]           trace_pc,
    output logic [TS_W-1:0]           trace_ts,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic [DROP_W-1:0]         drop_cnt,
    output logic                      stall_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [PC_W-1:0] pc;
        logic [TS_W-1:0] ts;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TS_W-1:0] cycle_cnt;
    logic [CW-1:0]   count_next;

    logic capture;
    logic pop;
    logic push;
    logic drop;
    entry_t head;

    // x0 is architecturally constant, so it is never logged whatever the mask says.
    assign capture = enable & wb_valid & WATCH_MASK[wb_rd] & (wb_rd != 5'd0);

    assign trace_valid = (count != '0);
    assign full        = (count == CW'(DEPTH));
    // Pop is only possible with a valid head, so an empty FIFO never bypasses.
    assign pop         = trace_valid & trace_ready;
    // A pop frees the slot the push lands in, so a full FIFO can still accept.
    assign push        = capture & (~full | pop);
    assign drop        = capture & full & ~pop;

    assign head       = mem[rd_ptr];
    assign trace_rd   = trace_valid ? head.rd   : '0;
    assign trace_data = trace_valid ? head.data : '0;
    assign trace_pc   = trace_valid ? head.pc   : '0;
    assign trace_ts   = trace_valid ? head.ts   : '0;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array carries no reset; trace_* are masked while empty,
    // so stale contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: wb_rd, data: wb_data, pc: wb_pc, ts: cycle_cnt};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TS_W'(1);
            count     <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

`ifdef TRACE_HALT_EN
    // Raised one entry early so the pipeline has a cycle to freeze writeback.
    always_ff @(posedge clk) begin
        if (rst) stall_req <= 1'b0;
        else     stall_req <= (count_next >= CW'(DEPTH - 1));
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer. Two instances share one stimulus stream:
//   u_a : WATCH_MASK all ones (x0 filtering), DROP_W=2 (drop saturation at 3)
//   u_b : WATCH_MASK 32'h8 (only x3 captured), default DROP_W
// A queue-based model tracks each instance; a negedge process compares every
// cycle, and the stimulus adds hand-computed literal expectations.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        trace_ready = 1'b0;

    logic        tv   [2];
    logic [4:0]  trd  [2];
    logic [63:0] tdat [2];
    logic [31:0] tpc  [2];
    logic [31:0] tts  [2];
    logic [4:0]  cnt  [2];
    logic        fl   [2];
    logic        stl  [2];
    logic [1:0]  drop_a;
    logic [15:0] drop_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.WATCH_MASK(32'hFFFF_FFFF), .DROP_W(2)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .trace_valid(tv[0]), .trace_ready(trace_ready),
        .trace_rd(trd[0]), .trace_data(tdat[0]), .trace_pc(tpc[0]), .trace_ts(tts[0]),
        .count(cnt[0]), .full(fl[0]), .drop_cnt(drop_a), .stall_req(stl[0])
    );

    wb_trace_buffer #(.WATCH_MASK(32'h0000_0008)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .trace_valid(tv[1]), .trace_ready(trace_ready),
        .trace_rd(trd[1]), .trace_data(tdat[1]), .trace_pc(tpc[1]), .trace_ts(tts[1]),
        .count(cnt[1]), .full(fl[1]), .drop_cnt(drop_b), .stall_req(stl[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] pc;
        logic [31:0] ts;
    } ev_t;

    ev_t         mq [2][$];
    int unsigned m_drop  [2];
    bit          m_stall [2];
    logic [31:0] m_ts;
    logic [31:0] m_mask  [2];
    int unsigned m_dmax  [2];
    string       pfx     [2];
    bit          started = 1'b0;

    initial begin
        m_mask[0] = 32'hFFFF_FFFF; m_mask[1] = 32'h0000_0008;
        m_dmax[0] = 3;             m_dmax[1] = 65535;
        pfx[0]    = "a.";          pfx[1]    = "b.";
    end

    task automatic model_step();
        bit          cap;
        bit          pop;
        bit          was_full;
        logic [31:0] mk;
        ev_t         e;
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                m_drop[i]  = 0;
                m_stall[i] = 1'b0;
            end else begin
                mk       = m_mask[i];
                cap      = enable && wb_valid && (wb_rd != 0) && mk[wb_rd];
                was_full = (mq[i].size() == DEPTH);
                pop      = (mq[i].size() != 0) && trace_ready;
                if (pop) void'(mq[i].pop_front());
                if (cap) begin
                    if (!was_full || pop) begin
                        e.rd = wb_rd; e.data = wb_data; e.pc = wb_pc; e.ts = m_ts;
                        mq[i].push_back(e);
                    end else if (m_drop[i] < m_dmax[i]) begin
                        m_drop[i]++;
                    end
                end
`ifdef TRACE_HALT_EN
                m_stall[i] = (mq[i].size() >= DEPTH - 1);
`endif
            end
        end
        m_ts = rst ? 32'd0 : m_ts + 32'd1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check({pfx[i], "valid"}, 64'(tv[i]), 64'(mq[i].size() != 0));
                check({pfx[i], "count"}, 64'(cnt[i]), 64'(mq[i].size()));
                check({pfx[i], "full"},  64'(fl[i]),  64'(mq[i].size() == DEPTH));
                check({pfx[i], "stall"}, 64'(stl[i]), 64'(m_stall[i]));
                check({pfx[i], "drop"},  (i == 0) ? 64'(drop_a) : 64'(drop_b), 64'(m_drop[i]));
                if (mq[i].size() != 0) begin
                    check({pfx[i], "rd"},   64'(trd[i]),  64'(mq[i][0].rd));
                    check({pfx[i], "data"}, tdat[i],      mq[i][0].data);
                    check({pfx[i], "pc"},   64'(tpc[i]),  64'(mq[i][0].pc));
                    check({pfx[i], "ts"},   64'(tts[i]),  64'(mq[i][0].ts));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Drives one cycle of inputs, then returns on the following negedge.
    task automatic cycle(input bit v, input logic [4:0] rd, input logic [63:0] d,
                         input logic [31:0] pc, input bit rdy);
        wb_valid    = v;
        wb_rd       = rd;
        wb_data     = d;
        wb_pc       = pc;
        trace_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First capture after reset stamps cycle 0 and is visible one edge later.
        cycle(1, 5'd7, 64'd9, 32'h10, 0);
        check("first.valid", 64'(tv[0]),  64'd1);
        check("first.rd",    64'(trd[0]), 64'd7);
        check("first.data",  tdat[0],     64'd9);
        check("first.pc",    64'(tpc[0]), 64'h10);
        check("first.ts",    64'(tts[0]), 64'd0);
        check("first.count", 64'(cnt[0]), 64'd1);
        check("first.b_cnt", 64'(cnt[1]), 64'd0);
        cycle(0, 5'd0, 64'd0, 32'h0, 1);
        check("drain1.count", 64'(cnt[0]), 64'd0);

        // x0 ignored even with an all-ones mask.
        cycle(1, 5'd0, 64'd5, 32'h14, 0);
        check("x0.count", 64'(cnt[0]), 64'd0);

        // Mask 0x8 keeps only x3.
        cycle(1, 5'd2, 64'd2, 32'h20, 0);
        cycle(1, 5'd3, 64'd3, 32'h24, 0);
        cycle(1, 5'd4, 64'd4, 32'h28, 0);
        check("mask.a_cnt", 64'(cnt[0]), 64'd3);
        check("mask.b_cnt", 64'(cnt[1]), 64'd1);
        check("mask.b_rd",  64'(trd[1]), 64'd3);
        repeat (3) cycle(0, 5'd0, 64'd0, 32'h0, 1);
        check("mask.drain", 64'(cnt[0]), 64'd0);

        // Overflow: 17 captures into 16 entries with no consumer.
        for (int i = 1; i <= 17; i++) begin
            cycle(1, 5'(i), 64'(i), 32'h100 + 32'(4 * i), 0);
`ifdef TRACE_HALT_EN
            check("fill.stall", 64'(stl[0]), 64'(i >= 15));
`else
            check("fill.stall", 64'(stl[0]), 64'd0);
`endif
        end
        check("ovf.full",  64'(fl[0]),  64'd1);
        check("ovf.count", 64'(cnt[0]), 64'd16);
        check("ovf.drop",  64'(drop_a), 64'd1);

        // Four more lost events saturate the 2-bit counter at 3.
        repeat (4) cycle(1, 5'd20, 64'hDEAD, 32'h300, 0);
        check("sat.drop", 64'(drop_a), 64'd3);

        // Full with simultaneous capture and pop: count holds, new entry goes to tail.
        cycle(1, 5'd21, 64'h77, 32'h200, 1);
        check("simul.count", 64'(cnt[0]),  64'd16);
        check("simul.drop",  64'(drop_a),  64'd3);
        check("simul.head",  tdat[0],      64'd2);

        // Drain in order: 2..16 then the tail entry 0x77.
        for (int k = 0; k < 16; k++) begin
            check("order.data", tdat[0], (k < 15) ? 64'(k + 2) : 64'h77);
            cycle(0, 5'd0, 64'd0, 32'h0, 1);
        end
        check("order.empty", 64'(tv[0]), 64'd0);

        // enable=0 blocks capture but draining continues.
        cycle(1, 5'd5, 64'h55, 32'h400, 0);
        cycle(1, 5'd6, 64'h66, 32'h404, 0);
        enable = 1'b0;
        repeat (3) cycle(1, 5'd8, 64'h88, 32'h408, 1);
        check("enable.count", 64'(cnt[0]), 64'd0);
        enable = 1'b1;

        // Reset with 5 entries queued wipes everything including drop_cnt.
        for (int i = 0; i < 5; i++) cycle(1, 5'(9 + i), 64'(100 + i), 32'h500, 0);
        check("pre_rst.count", 64'(cnt[0]), 64'd5);
        rst = 1'b1;
        cycle(0, 5'd0, 64'd0, 32'h0, 1);
        rst = 1'b0;
        check("rst.count", 64'(cnt[0]), 64'd0);
        check("rst.valid", 64'(tv[0]),  64'd0);
        check("rst.drop",  64'(drop_a), 64'd0);

        // Timestamp restarts from 0 after reset.
        cycle(1, 5'd3, 64'hAB, 32'h600, 0);
        check("rst.ts", 64'(tts[1]), 64'd0);
        repeat (3) cycle(0, 5'd0, 64'd0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
